// File: rtl/hex_rate_counter_pkg.sv
// Shared speed encodings and step-period helper for the hex rate counter.
package hex_rate_counter_pkg;

  localparam logic [1:0] SPEED_FAST = 2'b00;
  localparam logic [1:0] SPEED_1S   = 2'b01;
  localparam logic [1:0] SPEED_2S   = 2'b10;
  localparam logic [1:0] SPEED_4S   = 2'b11;

  // Number of clock edges between digit steps for a given speed select.
  function automatic int unsigned period(input int unsigned clk_hz, input logic [1:0] speed);
    int unsigned p;
    case (speed)
      SPEED_FAST: p = 1;
      SPEED_1S:   p = clk_hz;
      SPEED_2S:   p = 2 * clk_hz;
      default:    p = 4 * clk_hz;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// Clock divider: down-counts to zero, reloads on load or speed change, emits a step pulse.
module rate_divider
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned DIV_W  = (4 * CLK_HZ > 1) ? $clog2(4 * CLK_HZ) : 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [1:0]       speed_i,
  input  logic             load_i,
  output logic             step_o,
  output logic             reload_o,
  output logic [DIV_W-1:0] div_cnt_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       speed_q, speed_d;
  logic [DIV_W-1:0] reload_val;
  logic             speed_chg;

  assign reload_val = DIV_W'(period(CLK_HZ, speed_i) - 1);
  assign speed_chg  = (speed_i != speed_q);
  assign reload_o   = load_i | speed_chg;
  // A step only happens when neither a load nor a speed change takes the edge.
  assign step_o     = ~reload_o & enable_i & (div_cnt_q == '0);
  assign div_cnt_o  = div_cnt_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    speed_d   = speed_q;
    if (reload_o) begin
      div_cnt_d = reload_val;
      speed_d   = speed_i;
    end else if (enable_i) begin
      if (div_cnt_q == '0) div_cnt_d = reload_val;
      else                 div_cnt_d = div_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      speed_q   <= SPEED_FAST;
    end else begin
      div_cnt_q <= div_cnt_d;
      speed_q   <= speed_d;
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Rate-divided hex digit generator feeding a 7-segment decoder; supports pause and parallel load.
module hex_rate_counter
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic [3:0] digit,
  output logic       tick
);

  localparam int unsigned DIV_W = (4 * CLK_HZ > 1) ? $clog2(4 * CLK_HZ) : 1;

  logic [3:0]       digit_q, digit_d;
  logic             tick_q, tick_d;
  logic             step;
  logic             reload;
  logic [DIV_W-1:0] div_cnt;

  rate_divider #(
    .CLK_HZ (CLK_HZ),
    .DIV_W  (DIV_W)
  ) u_rate_divider (
    .clock_i   (clock),
    .reset_i   (reset),
    .enable_i  (enable),
    .speed_i   (speed),
    .load_i    (load),
    .step_o    (step),
    .reload_o  (reload),
    .div_cnt_o (div_cnt)
  );

  always_comb begin
    digit_d = digit_q;
    tick_d  = step;
    if (load)      digit_d = load_value;
    else if (step) digit_d = digit_q + 4'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_q <= 4'h0;
      tick_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      tick_q  <= tick_d;
    end
  end

  assign digit = digit_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter with CLK_HZ=4 and an expected-value queue.
module tb_hex_rate_counter;

  localparam int unsigned CLK_HZ = 4;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] speed;
  logic       load;
  logic [3:0] load_value;
  logic [3:0] digit;
  logic       tick;

  logic [4:0] exp_q[$];
  int         tests_run;
  int         tests_failed;

  hex_rate_counter #(.CLK_HZ(CLK_HZ)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .speed      (speed),
    .load       (load),
    .load_value (load_value),
    .digit      (digit),
    .tick       (tick)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // scoreboard compare: pops one expected {tick, digit}
  task automatic compare(input string tag);
    logic [4:0] e;
    logic [4:0] o;
    e = exp_q.pop_front();
    o = {tick, digit};
    tests_run++;
    assert (o === e) else begin
      tests_failed++;
      $error("FAIL %s: got tick=%b digit=%h, expected tick=%b digit=%h",
             tag, o[4], o[3:0], e[4], e[3:0]);
    end
  endtask

  // driver: expect {tick, digit} after the next rising edge
  task automatic cycle(input logic [3:0] d, input logic t, input string tag);
    exp_q.push_back({t, d});
    @(posedge clock);
    @(negedge clock);
    compare(tag);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset      = 1'b1;
    enable     = 1'b1;
    speed      = 2'b01;
    load       = 1'b0;
    load_value = 4'h0;

    repeat (2) @(negedge clock);
    exp_q.push_back({1'b0, 4'h0});
    compare("reset_state");
    reset = 1'b0;

    // release at speed 01: edge1 reloads, step at edge5 and edge9
    for (int i = 1; i <= 4; i++) cycle(4'h0, 1'b0, "startup_wait");
    cycle(4'h1, 1'b1, "first_step_edge5");
    for (int i = 0; i < 3; i++) cycle(4'h1, 1'b0, "interval_1");
    cycle(4'h2, 1'b1, "second_step_edge9");

    // pause with div_cnt = 2
    cycle(4'h2, 1'b0, "pre_pause");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cycle(4'h2, 1'b0, "paused_hold");
    enable = 1'b1;
    cycle(4'h2, 1'b0, "resume_1");
    cycle(4'h2, 1'b0, "resume_2");
    cycle(4'h3, 1'b1, "resume_step");

    // load wins over a step on the same edge
    for (int i = 0; i < 3; i++) cycle(4'h3, 1'b0, "count_to_zero");
    load = 1'b1;
    load_value = 4'hA;
    cycle(4'hA, 1'b0, "load_over_step");
    load = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'hA, 1'b0, "after_load_wait");
    cycle(4'hB, 1'b1, "after_load_step");

    // speed change mid-count: 01 -> 11
    cycle(4'hB, 1'b0, "pre_speed_change");
    speed = 2'b11;
    cycle(4'hB, 1'b0, "speed_change_edge");
    for (int i = 1; i <= 15; i++) cycle(4'hB, 1'b0, "speed4_wait");
    cycle(4'hC, 1'b1, "speed4_step");

    // fast mode wrap from E
    speed = 2'b00;
    load = 1'b1;
    load_value = 4'hE;
    cycle(4'hE, 1'b0, "load_E_fast");
    load = 1'b0;
    cycle(4'hF, 1'b1, "fast_F");
    cycle(4'h0, 1'b1, "fast_wrap_0");
    cycle(4'h1, 1'b1, "fast_1");

    // asynchronous reset mid-count with digit 7 and tick high
    speed = 2'b01;
    load = 1'b1;
    load_value = 4'h6;
    cycle(4'h6, 1'b0, "load_6");
    load = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'h6, 1'b0, "wait_to_7");
    cycle(4'h7, 1'b1, "step_to_7");
    #2 reset = 1'b1;
    #1;
    exp_q.push_back({1'b0, 4'h0});
    compare("async_reset_immediate");
    @(posedge clock);
    @(negedge clock);
    exp_q.push_back({1'b0, 4'h0});
    compare("reset_held");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cycle(4'h0, 1'b0, "post_reset_wait");
    cycle(4'h1, 1'b1, "post_reset_step");

    tests_run++;
    assert (exp_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL queue_empty: got %0d left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
